// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the SAR ADC sequencer: FSM states, strobe
// decode and counter sizing.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SAMP   = 3'd2,
    COMP   = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef struct packed {
    logic init;
    logic samp;
    logic comp;
    logic update;
  } strobes_t;

  localparam int DEF_NBITS         = 8;
  localparam int DEF_INIT_CYCLES   = 1;
  localparam int DEF_SAMP_CYCLES   = 2;
  localparam int DEF_COMP_CYCLES   = 1;
  localparam int DEF_UPDATE_CYCLES = 1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Down-counter holds at most (longest phase - 1).
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

  function automatic strobes_t phase_decode(input state_e s);
    strobes_t v;
    v = '{init: 1'b0, samp: 1'b0, comp: 1'b0, update: 1'b0};
    case (s)
      INIT:    v.init   = 1'b1;
      SAMP:    v.samp   = 1'b1;
      COMP:    v.comp   = 1'b1;
      UPDATE:  v.update = 1'b1;
      default: v        = '{init: 1'b0, samp: 1'b0, comp: 1'b0, update: 1'b0};
    endcase
    return v;
  endfunction

  localparam int DEF_CNT_W = cnt_width(max4(DEF_INIT_CYCLES, DEF_SAMP_CYCLES,
                                            DEF_COMP_CYCLES, DEF_UPDATE_CYCLES));
  localparam int DEF_BIT_W = $clog2(DEF_NBITS);

endpackage

// File: rtl/adc_sequencer_phase_cnt.sv
// Phase timer: loads (N-1) on phase entry and counts down to zero; the phase
// ends on the cycle the zero flag is high.
module seq_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= {W{1'b0}};
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/adc_sequencer.sv
// SAR ADC slice sequencer: phase FSM, MSB-first bit capture and a valid/ready
// result handoff with sticky overrun.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NBITS         = DEF_NBITS,
  parameter int INIT_CYCLES   = DEF_INIT_CYCLES,
  parameter int SAMP_CYCLES   = DEF_SAMP_CYCLES,
  parameter int COMP_CYCLES   = DEF_COMP_CYCLES,
  parameter int UPDATE_CYCLES = DEF_UPDATE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             comp_out,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_comp,
  output logic             seq_update,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun
);

  localparam int CNT_W = cnt_width(max4(INIT_CYCLES, SAMP_CYCLES, COMP_CYCLES, UPDATE_CYCLES));
  localparam int BIT_W = $clog2(NBITS);

  state_e            state_q, state_d;
  strobes_t          strb_q, strb_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [NBITS-1:0]  shift_q, shift_d;
  logic [NBITS-1:0]  result_q, result_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [NBITS-1:0]  cap_s;
  logic              load_s, dec_s, zero_s;
  logic [CNT_W-1:0]  load_val_s;
  logic              last_bit_s, comp_end_s, write_s, start_acc_s;

  seq_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (load_val_s),
    .dec      (dec_s),
    .zero     (zero_s)
  );

  // A start is only accepted while idle; it launches INIT one cycle later.
  assign start_acc_s = start && (state_q == IDLE);
  assign start_d     = start_acc_s;
  assign last_bit_s  = (bit_q == BIT_W'(NBITS - 1));
  assign comp_end_s  = (state_q == COMP) && zero_s;
  assign write_s     = comp_end_s && last_bit_s;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_q) state_d = INIT;   else state_d = IDLE;
      INIT:    if (zero_s)  state_d = SAMP;   else state_d = INIT;
      SAMP:    if (zero_s)  state_d = COMP;   else state_d = SAMP;
      COMP: begin
        if (zero_s) state_d = last_bit_s ? DONE : UPDATE;
        else        state_d = COMP;
      end
      UPDATE:  if (zero_s)  state_d = COMP;   else state_d = UPDATE;
      DONE:    if (cont)    state_d = INIT;   else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase timer reloads on every state change with the new phase length.
  always_comb begin
    load_s = (state_d != state_q);
    dec_s  = !load_s;
    case (state_d)
      INIT:    load_val_s = CNT_W'(INIT_CYCLES - 1);
      SAMP:    load_val_s = CNT_W'(SAMP_CYCLES - 1);
      COMP:    load_val_s = CNT_W'(COMP_CYCLES - 1);
      UPDATE:  load_val_s = CNT_W'(UPDATE_CYCLES - 1);
      default: load_val_s = CNT_W'(0);
    endcase
  end

  // Bit index and capture: compare k lands in bit NBITS-1-k.
  always_comb begin
    bit_d   = bit_q;
    shift_d = shift_q;
    for (int i = 0; i < NBITS; i++) begin
      cap_s[i] = (i == (NBITS - 1 - int'(bit_q))) ? comp_out : shift_q[i];
    end
    if ((state_d == INIT) && (state_q != INIT)) begin
      bit_d = {BIT_W{1'b0}};
    end else if (comp_end_s && !last_bit_s) begin
      bit_d = bit_q + BIT_W'(1);
    end else begin
      bit_d = bit_q;
    end
    if (comp_end_s) shift_d = cap_s;
    else            shift_d = shift_q;
  end

  // Result handoff and overrun tracking.
  always_comb begin
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (write_s) begin
      result_d = cap_s;
      valid_d  = 1'b1;
    end else if (valid_q && result_ready) begin
      valid_d  = 1'b0;
    end else begin
      valid_d  = valid_q;
    end
    if (start_acc_s) begin
      overrun_d = 1'b0;
    end else if (write_s && valid_q && !result_ready) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Strobes and busy are registered decodes of the next state.
  always_comb begin
    strb_d = phase_decode(state_d);
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      strb_q    <= '{init: 1'b0, samp: 1'b0, comp: 1'b0, update: 1'b0};
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      bit_q     <= {BIT_W{1'b0}};
      shift_q   <= {NBITS{1'b0}};
      result_q  <= {NBITS{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign seq_init     = strb_q.init;
  assign seq_samp     = strb_q.samp;
  assign seq_comp     = strb_q.comp;
  assign seq_update   = strb_q.update;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;

endmodule
